// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and default geometry for the load/store unit
package lsu_pkg;
  localparam int LSU_ADDR_W    = 8;
  localparam int LSU_DATA_W    = 8;
  localparam int LSU_MEM_DEPTH = 36;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } lsu_state_t;
endpackage

// File: rtl/lsu_addr_gen.sv
// rtl/lsu_addr_gen.sv - effective address adder and range compare (LSU_BOUNDS_CHECK_EN enables the compare)
module lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = LSU_ADDR_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] ea,
  output logic              out_of_range
);
  // Two's-complement offset makes a plain modular add correct for negative offsets.
  assign ea = base + offset;

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = ({{(32-ADDR_W){1'b0}}, ea} >= 32'(MEM_DEPTH));
`else
  assign out_of_range = 1'b0;
`endif
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator sequencing Rm/Wm around a held address
// Optional range checking is enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = LSU_ADDR_W,
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              fault,
  output logic              Rm,
  output logic              Wm,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] RegVal,
  input  logic [DATA_W-1:0] Data_out
);
  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ea;
  logic              oor;
  logic              is_store_q;
  logic              oor_q;
  logic              accept;

  lsu_addr_gen #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_addr_gen (
    .base        (base),
    .offset      (offset),
    .ea          (ea),
    .out_of_range(oor)
  );

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = oor_q ? DONE : ACCESS;
      ACCESS:  state_d = HOLD;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are decoded from the next state so every pin is a flop aligned with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      Rm         <= 1'b0;
      Wm         <= 1'b0;
      address    <= '0;
      RegVal     <= '0;
      rd_data    <= '0;
      is_store_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      busy  <= (state_d != IDLE);
      done  <= (state_d == DONE);
      fault <= (state_d == DONE) && oor_q;
      Rm    <= (state_d == ACCESS) && !is_store_q;
      Wm    <= (state_d == ACCESS) && is_store_q;
      if (accept) begin
        address    <= ea;
        RegVal     <= wr_data;
        is_store_q <= is_store;
        oor_q      <= oor;
      end
      if ((state_q == ACCESS) && !is_store_q) rd_data <= Data_out;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - load_store_unit paired with a 36-word memory and a reference model
module tb_load_store_unit;
  localparam int DEPTH = 36;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [7:0] base = '0, offset = '0, wr_data = '0;
  logic       busy, done, fault, Rm, Wm;
  logic [7:0] rd_data, address, RegVal, Data_out;

  load_store_unit #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .base(base),
    .offset(offset), .wr_data(wr_data), .busy(busy), .done(done),
    .rd_data(rd_data), .fault(fault), .Rm(Rm), .Wm(Wm), .address(address),
    .RegVal(RegVal), .Data_out(Data_out)
  );

  always #5 clk = ~clk;

  // memorydata stand-in: combinational read, synchronous write, no storage above DEPTH-1
  logic [7:0] mem [0:DEPTH-1];
  logic       mem_init = 1'b1;
  assign Data_out = (address < DEPTH) ? mem[address[5:0]] : 8'h00;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (Wm && address < DEPTH) begin
      mem[address[5:0]] <= RegVal;
    end
  end

  // reference model state
  logic [7:0] exp_mem [0:DEPTH-1];
  logic [7:0] rd_exp;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input bit st, input logic [7:0] b, input logic [7:0] o,
                         input logic [7:0] w, input logic [7:0] ea, input bit hold);
    bit flt, addr_bad, both, got_fault, busy0;
    int done_j, n_done, n_rd, n_wr;
    logic [7:0] wr_seen;
    flt = BOUNDS_ON && (ea >= DEPTH);
    done_j = -1; n_done = 0; n_rd = 0; n_wr = 0;
    addr_bad = 0; both = 0; got_fault = 0; busy0 = 0; wr_seen = '0;
    @(negedge clk);
    start = 1'b1; is_store = st; base = b; offset = o; wr_data = w;
    // j counts cycles after the edge that accepts start: SETUP, ACCESS, HOLD, DONE
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (done_j < 0) begin done_j = j; got_fault = fault; end
      end
      if (Rm) n_rd++;
      if (Wm) begin n_wr++; wr_seen = RegVal; end
      if (Rm && Wm) both = 1;
      if ((Rm || Wm) && address != ea) addr_bad = 1;
      if (j <= 2 && !flt && address != ea) addr_bad = 1;
      if (j == 0) busy0 = busy;
      if (!hold) start = 1'b0;
      else if (done_j >= 0 && j > done_j) start = 1'b0;
    end
    start = 1'b0;
    if (!flt) begin
      if (st) begin
        if (ea < DEPTH) exp_mem[ea[5:0]] = w;
      end else begin
        rd_exp = (ea < DEPTH) ? exp_mem[ea[5:0]] : 8'h00;
      end
    end
    check("done_latency", done_j, flt ? 1 : 3);
    check("done_count", n_done, 1);
    check("rm_count", n_rd, (!st && !flt) ? 1 : 0);
    check("wm_count", n_wr, (st && !flt) ? 1 : 0);
    check("fault", got_fault, flt);
    check("addr_stable", addr_bad, 0);
    check("rm_wm_excl", both, 0);
    check("busy", busy0, 1);
    check("address", address, ea);
    check("rd_data", rd_data, rd_exp);
    if (st && !flt) check("wr_data", wr_seen, w);
  endtask

  typedef struct {
    bit         st;
    logic [7:0] b, o, w, ea;
  } vec_t;

  initial begin
    vec_t tab [0:9];
    int   nd, ns;
    tab[0] = '{1, 8'd10,  8'd2,    8'hA5, 8'd12};
    tab[1] = '{0, 8'd12,  8'd0,    8'h00, 8'd12};
    tab[2] = '{0, 8'd20,  8'hFC,   8'h00, 8'd16};
    tab[3] = '{0, 8'hFF,  8'h01,   8'h00, 8'h00};
    tab[4] = '{1, 8'd40,  8'd0,    8'h5A, 8'd40};
    tab[5] = '{1, 8'd30,  8'd5,    8'hC3, 8'd35};
    tab[6] = '{0, 8'd35,  8'd0,    8'h00, 8'd35};
    tab[7] = '{0, 8'd36,  8'd0,    8'h00, 8'd36};
    tab[8] = '{1, 8'd5,   8'd0,    8'h3C, 8'd5};
    tab[9] = '{0, 8'd5,   8'd0,    8'h00, 8'd5};

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'(i * 7 + 3);
    rd_exp = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_rm", Rm, 0);
    check("rst_wm", Wm, 0);
    check("rst_address", address, 0);
    check("rst_regval", RegVal, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < 10; i++) run_cmd(tab[i].st, tab[i].b, tab[i].o, tab[i].w, tab[i].ea, 1'b0);

    // faulted (or unmapped) load after the 0x3C round trip
    run_cmd(1'b0, 8'd50, 8'd0, 8'h00, 8'd50, 1'b0);

    // start held high through the command and its DONE cycle
    run_cmd(1'b1, 8'd8, 8'd1, 8'h66, 8'd9, 1'b1);
    run_cmd(1'b0, 8'd9, 8'd0, 8'h00, 8'd9, 1'b1);
    run_cmd(1'b1, 8'd100, 8'd0, 8'h11, 8'd100, 1'b1);

    for (int i = 0; i < 40; i++) begin
      bit         st;
      logic [7:0] b, o;
      st = 1'($urandom_range(0, 1));
      b  = 8'($urandom_range(0, 44));
      o  = 8'($urandom_range(0, 11)) - 8'd4;
      if (i % 8 == 7) b = 8'($urandom_range(200, 255));
      run_cmd(st, b, o, 8'($urandom), b + o, 1'b0);
    end

    // reset during the ACCESS cycle of a store
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; base = 8'd7; offset = 8'd0; wr_data = 8'h77;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_wm", Wm, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_wm", Wm, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_address", address, 0);
    check("rst_mid_regval", RegVal, 0);
    check("rst_mid_rd_data", rd_data, 0);
    rd_exp = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    nd = 0; ns = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done) nd++;
      if (Rm || Wm) ns++;
    end
    check("rst_mid_no_done", nd, 0);
    check("rst_mid_no_strobe", ns, 0);

    run_cmd(1'b0, 8'd7, 8'd0, 8'h00, 8'd7, 1'b0);

    begin
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
      check("mem_image", bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
